stack_unit: RTL and testbench



---
 rtl/stack_unit_if.sv | 28 ++
 rtl/stack_unit.sv | 88 ++++++++
 tb/tb_stack_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/stack_unit_if.sv
// Stack port bundle: push/pop/clear requests in, top entry, count and status out.
interface stack_unit_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int AMOUNT_WIDTH = 16
);
    logic                    STACK_push_flag;
    logic [DATA_WIDTH-1:0]   STACK_push_value;
    logic                    STACK_pop_flag;
    logic                    STACK_clear_flag;
    logic [DATA_WIDTH-1:0]   STACK_TOP;
    logic [AMOUNT_WIDTH-1:0] STACK_AMOUNT;
    logic                    STACK_full;
    logic                    STACK_empty;
    logic                    STACK_overflow;
    logic                    STACK_underflow;

    modport master (
        output STACK_push_flag, STACK_push_value, STACK_pop_flag, STACK_clear_flag,
        input  STACK_TOP, STACK_AMOUNT, STACK_full, STACK_empty,
               STACK_overflow, STACK_underflow
    );

    modport slave (
        input  STACK_push_flag, STACK_push_value, STACK_pop_flag, STACK_clear_flag,
        output STACK_TOP, STACK_AMOUNT, STACK_full, STACK_empty,
               STACK_overflow, STACK_underflow
    );
endinterface

// File: rtl/stack_unit.sv
// LIFO stack; push/pop/clear take effect one cycle after sampling, top/status are combinational.
// No backpressure: pushes onto a full stack are dropped and flagged, pops on empty are flagged.
module stack_unit #(
    parameter int DEPTH        = 64,
    parameter int DATA_WIDTH   = 32,
    parameter int AMOUNT_WIDTH = 16
) (
    input  logic         clock,
    input  logic         reset,
    stack_unit_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AMOUNT_WIDTH-1:0] DEPTH_A = AMOUNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [AMOUNT_WIDTH-1:0] amt, amt_nxt;
    logic                    ovf, ovf_nxt;
    logic                    udf, udf_nxt;
    logic                    wr_en;
    logic [IDX_W-1:0]        wr_idx;
    logic [IDX_W-1:0]        top_idx;
    logic                    full, empty;

    assign full    = (amt == DEPTH_A);
    assign empty   = (amt == '0);
    assign top_idx = IDX_W'(amt - 1'b1);

    always_comb begin
        amt_nxt = amt;
        ovf_nxt = ovf;
        udf_nxt = udf;
        wr_en   = 1'b0;
        wr_idx  = IDX_W'(amt);
        if (bus.STACK_clear_flag) begin
            amt_nxt = '0;
            ovf_nxt = 1'b0;
            udf_nxt = 1'b0;
        end else if (bus.STACK_push_flag && bus.STACK_pop_flag) begin
            // Simultaneous push+pop replaces the top; on empty it degenerates to a plain push.
            wr_en = 1'b1;
            if (empty) begin
                wr_idx  = '0;
                amt_nxt = AMOUNT_WIDTH'(1);
            end else begin
                wr_idx = top_idx;
            end
        end else if (bus.STACK_push_flag) begin
            if (full) begin
                ovf_nxt = 1'b1;
            end else begin
                wr_en   = 1'b1;
                amt_nxt = amt + 1'b1;
            end
        end else if (bus.STACK_pop_flag) begin
            if (empty) begin
                udf_nxt = 1'b1;
            end else begin
                amt_nxt = amt - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            amt <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            amt <= amt_nxt;
            ovf <= ovf_nxt;
            udf <= udf_nxt;
        end
    end

    // Storage has no reset so it can map onto a RAM; validity is tracked by amt alone.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            mem[wr_idx] <= bus.STACK_push_value;
        end
    end

    assign bus.STACK_TOP       = empty ? '0 : mem[top_idx];
    assign bus.STACK_AMOUNT    = amt;
    assign bus.STACK_full      = full;
    assign bus.STACK_empty     = empty;
    assign bus.STACK_overflow  = ovf;
    assign bus.STACK_underflow = udf;
endmodule

// File: tb/tb_stack_unit.sv
// Directed vector table plus randomized traffic checked against a queue-based stack model.
module tb_stack_unit;
    localparam int DEPTH = 4;
    localparam int NVEC  = 29;

    logic clock;
    logic reset;

    stack_unit_if #(.DATA_WIDTH(32), .AMOUNT_WIDTH(16)) bus ();

    stack_unit #(.DEPTH(DEPTH), .DATA_WIDTH(32), .AMOUNT_WIDTH(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        clr;
        logic        push;
        logic        pop;
        logic [31:0] val;
        logic [31:0] e_top;
        logic [15:0] e_amt;
        logic        e_full;
        logic        e_empty;
        logic        e_ovf;
        logic        e_udf;
    } vec_t;

    vec_t vecs [NVEC];

    int total  = 0;
    int passed = 0;

    logic [31:0] mq [$];
    bit          m_ovf;
    bit          m_udf;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    endtask

    task automatic check_all(input string tag, input int idx,
                             input logic [31:0] e_top, input logic [15:0] e_amt,
                             input logic e_full, input logic e_empty,
                             input logic e_ovf, input logic e_udf);
        chk({tag, "_top"},   idx, bus.STACK_TOP, e_top);
        chk({tag, "_amt"},   idx, 32'(bus.STACK_AMOUNT), 32'(e_amt));
        chk({tag, "_full"},  idx, 32'(bus.STACK_full), 32'(e_full));
        chk({tag, "_empty"}, idx, 32'(bus.STACK_empty), 32'(e_empty));
        chk({tag, "_ovf"},   idx, 32'(bus.STACK_overflow), 32'(e_ovf));
        chk({tag, "_udf"},   idx, 32'(bus.STACK_underflow), 32'(e_udf));
    endtask

    // Reference behaviour expressed directly on a queue whose back is the top of stack.
    task automatic model_step(input logic r, input logic c, input logic pu, input logic po,
                              input logic [31:0] v);
        if (r || c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (pu && po) begin
            if (mq.size() > 0) mq[mq.size()-1] = v;
            else mq.push_back(v);
        end else if (pu) begin
            if (mq.size() < DEPTH) mq.push_back(v);
            else m_ovf = 1'b1;
        end else if (po) begin
            if (mq.size() > 0) void'(mq.pop_back());
            else m_udf = 1'b1;
        end
    endtask

    task automatic cycle(input logic r, input logic c, input logic pu, input logic po,
                         input logic [31:0] v);
        reset                = r;
        bus.STACK_clear_flag = c;
        bus.STACK_push_flag  = pu;
        bus.STACK_pop_flag   = po;
        bus.STACK_push_value = v;
        @(posedge clock);
        model_step(r, c, pu, po, v);
        #1;
    endtask

    initial begin
        logic [31:0] m_top;
        reset                = 1'b1;
        bus.STACK_clear_flag = 1'b0;
        bus.STACK_push_flag  = 1'b0;
        bus.STACK_pop_flag   = 1'b0;
        bus.STACK_push_value = '0;

        //           rst clr psh pop val           top           amt full emp ovf udf
        vecs[0]  = '{1, 0, 0, 0, 32'h0,        32'h0,        16'd0, 0, 1, 0, 0};
        vecs[1]  = '{0, 0, 1, 0, 32'h11111111, 32'h11111111, 16'd1, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 1, 0, 32'h22222222, 32'h22222222, 16'd2, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 1, 32'h0,        32'h11111111, 16'd1, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 1, 32'h0,        32'h0,        16'd0, 0, 1, 0, 0};
        vecs[5]  = '{0, 0, 0, 1, 32'h0,        32'h0,        16'd0, 0, 1, 0, 1};
        vecs[6]  = '{0, 0, 0, 0, 32'h0,        32'h0,        16'd0, 0, 1, 0, 1};
        vecs[7]  = '{0, 1, 0, 0, 32'h0,        32'h0,        16'd0, 0, 1, 0, 0};
        vecs[8]  = '{0, 0, 1, 0, 32'd1,        32'd1,        16'd1, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 1, 0, 32'd2,        32'd2,        16'd2, 0, 0, 0, 0};
        vecs[10] = '{0, 0, 1, 0, 32'd3,        32'd3,        16'd3, 0, 0, 0, 0};
        vecs[11] = '{0, 0, 1, 0, 32'd4,        32'd4,        16'd4, 1, 0, 0, 0};
        vecs[12] = '{0, 0, 1, 0, 32'd5,        32'd4,        16'd4, 1, 0, 1, 0};
        vecs[13] = '{0, 0, 0, 1, 32'h0,        32'd3,        16'd3, 0, 0, 1, 0};
        vecs[14] = '{0, 1, 1, 0, 32'h55,       32'h0,        16'd0, 0, 1, 0, 0};
        vecs[15] = '{0, 0, 1, 0, 32'h99,       32'h99,       16'd1, 0, 0, 0, 0};
        vecs[16] = '{0, 0, 1, 0, 32'hAA,       32'hAA,       16'd2, 0, 0, 0, 0};
        vecs[17] = '{0, 0, 1, 1, 32'hBB,       32'hBB,       16'd2, 0, 0, 0, 0};
        vecs[18] = '{0, 0, 1, 0, 32'd1,        32'd1,        16'd3, 0, 0, 0, 0};
        vecs[19] = '{0, 0, 1, 0, 32'd2,        32'd2,        16'd4, 1, 0, 0, 0};
        vecs[20] = '{0, 0, 1, 1, 32'hDD,       32'hDD,       16'd4, 1, 0, 0, 0};
        vecs[21] = '{0, 1, 0, 0, 32'h0,        32'h0,        16'd0, 0, 1, 0, 0};
        vecs[22] = '{0, 0, 1, 1, 32'hCC,       32'hCC,       16'd1, 0, 0, 0, 0};
        vecs[23] = '{0, 0, 1, 0, 32'd7,        32'd7,        16'd2, 0, 0, 0, 0};
        vecs[24] = '{0, 0, 1, 0, 32'd8,        32'd8,        16'd3, 0, 0, 0, 0};
        vecs[25] = '{0, 0, 1, 0, 32'd9,        32'd9,        16'd4, 1, 0, 0, 0};
        vecs[26] = '{0, 0, 1, 0, 32'hA,        32'd9,        16'd4, 1, 0, 1, 0};
        vecs[27] = '{1, 0, 1, 0, 32'h55,       32'h0,        16'd0, 0, 1, 0, 0};
        vecs[28] = '{0, 0, 0, 1, 32'h0,        32'h0,        16'd0, 0, 1, 0, 1};

        for (int i = 0; i < NVEC; i++) begin
            cycle(vecs[i].rst, vecs[i].clr, vecs[i].push, vecs[i].pop, vecs[i].val);
            check_all("vec", i, vecs[i].e_top, vecs[i].e_amt, vecs[i].e_full,
                      vecs[i].e_empty, vecs[i].e_ovf, vecs[i].e_udf);
        end

        // Sticky underflow must survive idle cycles and plain pushes.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, (i == 2), 0, 32'hF00D);
            check_all("sticky", i, (i == 2) ? 32'hF00D : 32'h0, (i == 2) ? 16'd1 : 16'd0,
                      1'b0, (i != 2), 1'b0, 1'b1);
        end

        cycle(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 3000; i++) begin
            logic r, c, pu, po;
            r  = ($urandom_range(99) == 0);
            c  = ($urandom_range(49) == 0);
            pu = ($urandom_range(99) < 50);
            po = ($urandom_range(99) < 45);
            cycle(r, c, pu, po, $urandom);
            m_top = (mq.size() > 0) ? mq[mq.size()-1] : 32'h0;
            check_all("rand", i, m_top, 16'(mq.size()), (mq.size() == DEPTH),
                      (mq.size() == 0), m_ovf, m_udf);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
